// File: rtl/pixel_comp_pkg.sv
// pixel_comp_pkg: shared colours, scroll state encoding and pipeline depth for pixel_compositor.
package pixel_comp_pkg;
    localparam logic [11:0] DEF_CHAR_COLOR     = 12'h000;
    localparam logic [11:0] DEF_OBSTACLE_COLOR = 12'h000;
    localparam logic [11:0] DEF_BG_COLOR       = 12'hFFF;
    localparam int PIPE_LATENCY = 3;
    typedef enum logic {S_IDLE, S_SCROLL} scroll_state_t;
endpackage

// File: rtl/span_hit.sv
// span_hit: unsigned box test (px,py) in [ox,ox+w) x [oy,oy+h).
module span_hit #(
    parameter int W = 14
) (
    input  logic [W-1:0] px,
    input  logic [W-1:0] py,
    input  logic [W-1:0] ox,
    input  logic [W-1:0] oy,
    input  logic [W-1:0] w,
    input  logic [W-1:0] h,
    output logic         hit
);
    logic [W:0] dx, dy;
    // A point left of / above the box wraps to a huge difference and misses.
    always_comb begin
        dx  = {1'b0, px} - {1'b0, ox};
        dy  = {1'b0, py} - {1'b0, oy};
        hit = (dx < {1'b0, w}) && (dy < {1'b0, h});
    end
endmodule

// File: rtl/pixel_compositor.sv
// pixel_compositor: 3-stage scan-to-pixel pipeline with per-frame shadowed scene, camera and collision flag.
// PIXEL_COMPOSITOR_SMOOTH_SCROLL_EN enables stepped camera scrolling and scroll_busy.
module pixel_compositor
    import pixel_comp_pkg::*;
#(
    parameter int OBSTACLE_NUM    = 10,
    parameter int PHY_WIDTH       = 14,
    parameter int SCREEN_WIDTH    = 10,
    parameter int PIXEL_WIDTH     = 12,
    parameter int BLOCK_LEN_WIDTH = 4,
    parameter int CAM_WIDTH       = 5,
    parameter int BLOCK_WIDTH     = 480,
    parameter int CHAR_WIDTH_X    = 32,
    parameter int CHAR_WIDTH_Y    = 32,
    parameter int OBSTACLE_WIDTH  = 10,
    parameter int MAP_X_OFFSET    = 120,
    parameter int MAP_WIDTH_X     = 480,
    parameter int SCROLL_STEP     = 160,
    parameter logic [PIXEL_WIDTH-1:0] CHAR_COLOR     = PIXEL_WIDTH'(DEF_CHAR_COLOR),
    parameter logic [PIXEL_WIDTH-1:0] OBSTACLE_COLOR = PIXEL_WIDTH'(DEF_OBSTACLE_COLOR),
    parameter logic [PIXEL_WIDTH-1:0] BG_COLOR       = PIXEL_WIDTH'(DEF_BG_COLOR)
) (
    input  logic                                  sys_clk,
    input  logic                                  sys_rst_n,
    input  logic                                  pix_tick,
    input  logic                                  frame_start,
    input  logic                                  video_on,
    input  logic [1:0]                            sync_in,
    input  logic [SCREEN_WIDTH-1:0]               x,
    input  logic [SCREEN_WIDTH-1:0]               y,
    input  logic [CAM_WIDTH-1:0]                  camera_y,
    input  logic [PHY_WIDTH-1:0]                  char_abs_x,
    input  logic [PHY_WIDTH-1:0]                  char_abs_y,
    input  logic [OBSTACLE_NUM*PHY_WIDTH-1:0]     obstacle_abs_pos_x,
    input  logic [OBSTACLE_NUM*PHY_WIDTH-1:0]     obstacle_abs_pos_y,
    input  logic [OBSTACLE_NUM*BLOCK_LEN_WIDTH-1:0] obstacle_block_width,
    output logic [PHY_WIDTH-1:0]                  map_x,
    output logic [PHY_WIDTH-1:0]                  map_y,
    input  logic [PIXEL_WIDTH-1:0]                map_rgb,
    output logic [PIXEL_WIDTH-1:0]                rgb,
    output logic [1:0]                            sync_out,
    output logic                                  scroll_busy,
    output logic                                  frame_collision
);
    localparam int PW = PHY_WIDTH;
    localparam int BL = BLOCK_LEN_WIDTH;

    logic [PW-1:0] char_x_s, char_y_s, cam_off, cam_next, target, wy, wx0;
    logic [OBSTACLE_NUM*PW-1:0] obs_x_s, obs_y_s;
    logic [OBSTACLE_NUM*BL-1:0] obs_len_s;
    logic [OBSTACLE_NUM-1:0] obs_hits;
    logic [SCREEN_WIDTH-1:0] x0;
    logic [1:0] sync0, sync1;
    logic vid0, vid1, char_hit, char_hit1, obs_hit1, win1, acc, coll_hit, win;

    always_comb begin
        target   = PW'(32'(camera_y) * BLOCK_WIDTH);
        wy       = PW'(y) + cam_off;
        wx0      = PW'(x0);
        win      = (32'(x0) >= MAP_X_OFFSET) && (32'(x0) < MAP_X_OFFSET + MAP_WIDTH_X);
        coll_hit = pix_tick && vid0 && char_hit && (|obs_hits);
    end

`ifdef PIXEL_COMPOSITOR_SMOOTH_SCROLL_EN
    scroll_state_t state;
    // Move at most one step per frame, landing exactly on the target.
    always_comb
        cam_next = (cam_off < target)
            ? ((target - cam_off > PW'(SCROLL_STEP)) ? cam_off + PW'(SCROLL_STEP) : target)
            : ((cam_off - target > PW'(SCROLL_STEP)) ? cam_off - PW'(SCROLL_STEP) : target);

    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            state       <= S_IDLE;
            scroll_busy <= 1'b0;
        end else if (frame_start) begin
            state       <= (cam_next != target) ? S_SCROLL : S_IDLE;
            scroll_busy <= (cam_next != target);
        end
`else
    always_comb cam_next = target;
    assign scroll_busy = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            char_x_s  <= '0;
            char_y_s  <= '0;
            obs_x_s   <= '0;
            obs_y_s   <= '0;
            obs_len_s <= '0;
            cam_off   <= '0;
        end else if (frame_start) begin
            char_x_s  <= char_abs_x;
            char_y_s  <= char_abs_y;
            obs_x_s   <= obstacle_abs_pos_x;
            obs_y_s   <= obstacle_abs_pos_y;
            obs_len_s <= obstacle_block_width;
            cam_off   <= cam_next;
        end

    span_hit #(.W(PW)) u_char (
        .px(wx0), .py(map_y), .ox(char_x_s), .oy(char_y_s),
        .w(PW'(CHAR_WIDTH_X)), .h(PW'(CHAR_WIDTH_Y)), .hit(char_hit)
    );

    for (genvar i = 0; i < OBSTACLE_NUM; i++) begin : g_obs
        span_hit #(.W(PW)) u_obs (
            .px(wx0), .py(map_y),
            .ox(obs_x_s[i*PW +: PW]), .oy(obs_y_s[i*PW +: PW]),
            .w(PW'(32'(obs_len_s[i*BL +: BL]) * OBSTACLE_WIDTH)),
            .h(PW'(OBSTACLE_WIDTH)), .hit(obs_hits[i])
        );
    end

    // map_y doubles as the stage-0 world y used by the hit testers.
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            x0        <= '0;
            vid0      <= 1'b0;
            sync0     <= '0;
            map_x     <= '0;
            map_y     <= '0;
            char_hit1 <= 1'b0;
            obs_hit1  <= 1'b0;
            win1      <= 1'b0;
            vid1      <= 1'b0;
            sync1     <= '0;
            rgb       <= '0;
            sync_out  <= '0;
        end else if (pix_tick) begin
            x0        <= x;
            vid0      <= video_on;
            sync0     <= sync_in;
            map_x     <= PW'(x) - PW'(MAP_X_OFFSET);
            map_y     <= wy;
            char_hit1 <= char_hit;
            obs_hit1  <= |obs_hits;
            win1      <= win;
            vid1      <= vid0;
            sync1     <= sync0;
            rgb       <= !vid1 ? '0 : char_hit1 ? CHAR_COLOR : obs_hit1 ? OBSTACLE_COLOR :
                         win1 ? map_rgb : BG_COLOR;
            sync_out  <= sync1;
        end

    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            acc             <= 1'b0;
            frame_collision <= 1'b0;
        end else if (frame_start) begin
            frame_collision <= acc | coll_hit;
            acc             <= 1'b0;
        end else if (coll_hit) begin
            acc <= 1'b1;
        end
endmodule

// File: tb/tb_pixel_compositor.sv
// tb_pixel_compositor: table-driven pixel vectors plus directed scroll, stall, collision and reset sequences.
module tb_pixel_compositor;
    import pixel_comp_pkg::*;

    localparam int ON = 10;
    localparam logic [11:0] CHAR_C = 12'hC00;
    localparam logic [11:0] OBS_C  = 12'h0C0;
    localparam logic [11:0] BG_C   = 12'hFFF;
    localparam int K_BLACK = 0, K_CHAR = 1, K_OBS = 2, K_MAP = 3, K_BG = 4;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       vid;
        logic [1:0] sync;
        int         kind;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0, pix_tick = 1'b0, frame_start = 1'b0, video_on = 1'b0;
    logic [1:0] sync_in = '0, sync_out;
    logic [9:0] x = '0, y = '0;
    logic [4:0] camera_y = '0;
    logic [13:0] char_x = '0, char_y = '0, map_x, map_y;
    logic [ON*14-1:0] obs_x = '0, obs_y = '0;
    logic [ON*4-1:0] obs_len = '0;
    logic [11:0] map_rgb = '0, rgb;
    logic scroll_busy, frame_collision;
    int n_cmp = 0, n_bad = 0;
    vec_t vecs[20];

    pixel_compositor #(
        .CHAR_COLOR(CHAR_C), .OBSTACLE_COLOR(OBS_C), .BG_COLOR(BG_C)
    ) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .pix_tick(pix_tick), .frame_start(frame_start),
        .video_on(video_on), .sync_in(sync_in), .x(x), .y(y), .camera_y(camera_y),
        .char_abs_x(char_x), .char_abs_y(char_y),
        .obstacle_abs_pos_x(obs_x), .obstacle_abs_pos_y(obs_y),
        .obstacle_block_width(obs_len), .map_x(map_x), .map_y(map_y), .map_rgb(map_rgb),
        .rgb(rgb), .sync_out(sync_out), .scroll_busy(scroll_busy),
        .frame_collision(frame_collision)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] rom(input logic [13:0] mx, input logic [13:0] my);
        return {mx[5:0], my[5:0]};
    endfunction

    // Map ROM model: one pix_tick of read latency.
    always_ff @(posedge clk) if (pix_tick) map_rgb <= rom(map_x, map_y);

    function automatic logic [11:0] exp_rgb(input vec_t v, input logic [13:0] cam);
        case (v.kind)
            K_CHAR:  return CHAR_C;
            K_OBS:   return OBS_C;
            K_MAP:   return rom(14'(v.x) - 14'd120, 14'(v.y) + cam);
            K_BG:    return BG_C;
            default: return 12'h000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic pt, input logic fs);
        @(negedge clk);
        pix_tick = pt;
        frame_start = fs;
        @(posedge clk);
        #1;
        pix_tick = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic set_obs(input int i, input logic [13:0] ox, input logic [13:0] oy, input logic [3:0] len);
        obs_x[i*14 +: 14] = ox;
        obs_y[i*14 +: 14] = oy;
        obs_len[i*4 +: 4] = len;
    endtask

    task automatic pixel(input logic [9:0] px, input logic [9:0] py, input logic vid);
        x = px;
        y = py;
        video_on = vid;
    endtask

    initial begin
        vecs[0]  = '{10'd210, 10'd110, 1'b1, 2'd1, K_CHAR};
        vecs[1]  = '{10'd199, 10'd110, 1'b1, 2'd2, K_MAP};
        vecs[2]  = '{10'd329, 10'd59,  1'b1, 2'd3, K_OBS};
        vecs[3]  = '{10'd330, 10'd59,  1'b1, 2'd0, K_MAP};
        vecs[4]  = '{10'd300, 10'd50,  1'b1, 2'd1, K_OBS};
        vecs[5]  = '{10'd329, 10'd60,  1'b1, 2'd2, K_MAP};
        vecs[6]  = '{10'd299, 10'd55,  1'b1, 2'd3, K_MAP};
        vecs[7]  = '{10'd210, 10'd110, 1'b0, 2'd0, K_BLACK};
        vecs[8]  = '{10'd100, 10'd20,  1'b1, 2'd1, K_BG};
        vecs[9]  = '{10'd600, 10'd20,  1'b1, 2'd2, K_BG};
        vecs[10] = '{10'd599, 10'd20,  1'b1, 2'd3, K_MAP};
        vecs[11] = '{10'd231, 10'd131, 1'b1, 2'd0, K_CHAR};
        vecs[12] = '{10'd232, 10'd131, 1'b1, 2'd1, K_OBS};
        vecs[13] = '{10'd200, 10'd99,  1'b1, 2'd2, K_MAP};
        vecs[14] = '{10'd225, 10'd125, 1'b1, 2'd3, K_CHAR};
        vecs[15] = '{10'd240, 10'd134, 1'b1, 2'd0, K_OBS};
        vecs[16] = '{10'd245, 10'd134, 1'b1, 2'd1, K_MAP};
        vecs[17] = '{10'd240, 10'd135, 1'b1, 2'd2, K_MAP};
        vecs[18] = '{10'd120, 10'd7,   1'b1, 2'd3, K_MAP};
        vecs[19] = '{10'd119, 10'd7,   1'b1, 2'd0, K_BG};

        #23;
        chk("reset rgb", 32'(rgb), 0);
        chk("reset sync_out", 32'(sync_out), 0);
        chk("reset map_x", 32'(map_x), 0);
        chk("reset map_y", 32'(map_y), 0);
        chk("reset scroll_busy", 32'(scroll_busy), 0);
        chk("reset frame_collision", 32'(frame_collision), 0);
        rst_n = 1'b1;

        // Scene: char (200,100); obstacle0 (300,50) len 3; obstacle1 (225,125) len 2.
        char_x = 14'd200;
        char_y = 14'd100;
        set_obs(0, 14'd300, 14'd50, 4'd3);
        set_obs(1, 14'd225, 14'd125, 4'd2);
        tick(1'b0, 1'b1);
        for (int k = 0; k < 22; k++) begin
            if (k < 20) begin
                pixel(vecs[k].x, vecs[k].y, vecs[k].vid);
                sync_in = vecs[k].sync;
            end
            tick(1'b1, 1'b0);
            if (k >= 2) begin
                chk($sformatf("vec%0d rgb", k - 2), 32'(rgb), 32'(exp_rgb(vecs[k-2], 14'd0)));
                chk($sformatf("vec%0d sync", k - 2), 32'(sync_out), 32'(vecs[k-2].sync));
            end
        end

        // Length 0 obstacle never draws.
        set_obs(0, 14'd300, 14'd50, 4'd0);
        tick(1'b0, 1'b1);
        pixel(10'd310, 10'd55, 1'b1);
        repeat (3) tick(1'b1, 1'b0);
        chk("len0 rgb", 32'(rgb), 32'(rom(14'd190, 14'd55)));

        // Collision accumulates over a frame and reports at the next frame_start.
        char_x = 14'd100;
        char_y = 14'd100;
        set_obs(0, 14'd110, 14'd110, 4'd1);
        set_obs(1, 14'd0, 14'd0, 4'd0);
        tick(1'b0, 1'b1);
        pixel(10'd115, 10'd115, 1'b1);
        repeat (2) tick(1'b1, 1'b0);
        pixel(10'd50, 10'd50, 1'b0);
        repeat (2) tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        chk("collision set", 32'(frame_collision), 1);
        set_obs(0, 14'd400, 14'd400, 4'd1);
        tick(1'b0, 1'b1);
        pixel(10'd115, 10'd115, 1'b1);
        repeat (2) tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        chk("collision clear", 32'(frame_collision), 0);

        // Stall: stages hold with a char pixel in flight behind background.
        pixel(10'd100, 10'd20, 1'b1);
        sync_in = 2'd2;
        repeat (3) tick(1'b1, 1'b0);
        pixel(10'd115, 10'd110, 1'b1);
        sync_in = 2'd1;
        tick(1'b1, 1'b0);
        pixel(10'd599, 10'd20, 1'b1);
        sync_in = 2'd3;
        repeat (5) tick(1'b0, 1'b0);
        chk("stall rgb", 32'(rgb), 32'(BG_C));
        chk("stall sync", 32'(sync_out), 2);
        pixel(10'd100, 10'd20, 1'b1);
        sync_in = 2'd0;
        repeat (2) tick(1'b1, 1'b0);
        chk("resume rgb", 32'(rgb), 32'(CHAR_C));
        chk("resume sync", 32'(sync_out), 1);

        // Camera scroll observed through map_y = y + cam_off.
        camera_y = 5'd1;
`ifdef PIXEL_COMPOSITOR_SMOOTH_SCROLL_EN
        for (int s = 1; s <= 3; s++) begin
            tick(1'b0, 1'b1);
            pixel(10'd0, 10'd0, 1'b0);
            tick(1'b1, 1'b0);
            chk($sformatf("scroll%0d cam", s), 32'(map_y), 32'(160 * s));
            chk($sformatf("scroll%0d busy", s), 32'(scroll_busy), (s < 3) ? 1 : 0);
        end
`else
        tick(1'b0, 1'b1);
        pixel(10'd0, 10'd0, 1'b0);
        tick(1'b1, 1'b0);
        chk("jump cam", 32'(map_y), 480);
        chk("jump busy", 32'(scroll_busy), 0);
`endif
        // frame_start together with pix_tick: that sample still sees the old camera.
        camera_y = 5'd2;
        tick(1'b1, 1'b1);
        chk("fs+tick old cam", 32'(map_y), 480);
        tick(1'b1, 1'b0);
`ifdef PIXEL_COMPOSITOR_SMOOTH_SCROLL_EN
        chk("fs+tick new cam", 32'(map_y), 640);
        chk("mid-scroll busy", 32'(scroll_busy), 1);
`else
        chk("fs+tick new cam", 32'(map_y), 960);
`endif

        // Asynchronous reset mid-line while scrolling.
        pixel(10'd100, 10'd20, 1'b1);
        sync_in = 2'd3;
        repeat (3) tick(1'b1, 1'b0);
        chk("pre-reset rgb", 32'(rgb), 32'(BG_C));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst rgb", 32'(rgb), 0);
        chk("async rst sync", 32'(sync_out), 0);
        chk("async rst map_x", 32'(map_x), 0);
        chk("async rst map_y", 32'(map_y), 0);
        chk("async rst busy", 32'(scroll_busy), 0);
        chk("async rst coll", 32'(frame_collision), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pixel(10'd100, 10'd5, 1'b1);
        tick(1'b1, 1'b0);
        chk("refill1 rgb", 32'(rgb), 0);
        chk("refill cam reset", 32'(map_y), 5);
        tick(1'b1, 1'b0);
        chk("refill2 rgb", 32'(rgb), 0);
        tick(1'b1, 1'b0);
        chk("refill3 rgb", 32'(rgb), 32'(BG_C));
        chk("refill3 sync", 32'(sync_out), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
